// File: rtl/global_parameters.sv
// Shared perceptron predictor parameters and types.
// Sizes for the weight tables and the table-access scheduler.
package global_parameters;

    localparam int PERCEPTRON_TABLE_NUM_ENTRIES = 2048;
    localparam int PERCEPTRON_NUM_WEIGHTS = 32;
    localparam int PERCEPTRON_WEIGHT_WIDTH = 10;
    localparam int NUM_TABLES = 4;

    localparam int PERCEPTRON_INDEX_WIDTH =
        $clog2(PERCEPTRON_TABLE_NUM_ENTRIES);
    localparam int PERCEPTRON_ROW_WIDTH =
        PERCEPTRON_NUM_WEIGHTS * PERCEPTRON_WEIGHT_WIDTH;

    localparam int SCHED_QUEUE_DEPTH = 4;
    localparam int SCHED_MAX_DEFER = 8;

    typedef struct packed {
        logic [PERCEPTRON_INDEX_WIDTH-1:0] index;
        logic [PERCEPTRON_ROW_WIDTH-1:0]   wdata;
    } train_entry_t;

endpackage

// File: rtl/perceptron_table_scheduler_queue.sv
// In-order training write queue with a youngest-match
// associative lookup used for read forwarding.
module train_write_queue
    import global_parameters::*;
#(
    parameter int DEPTH = SCHED_QUEUE_DEPTH,
    parameter int IDX_W = PERCEPTRON_INDEX_WIDTH,
    parameter int ROW_W = PERCEPTRON_ROW_WIDTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_index_i,
    input  logic [ROW_W-1:0] push_wdata_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_index_o,
    output logic [ROW_W-1:0] head_wdata_o,
    output logic [CNT_W-1:0] count_o,
    input  logic [IDX_W-1:0] lookup_index_i,
    output logic             lookup_hit_o,
    output logic [ROW_W-1:0] lookup_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [ROW_W-1:0] row_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] lk_slot;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        cnt_d    = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            idx_q[wr_ptr_q] <= push_index_i;
            row_q[wr_ptr_q] <= push_wdata_i;
        end
    end

    // Walk oldest to youngest so the last match left standing is youngest.
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        lk_slot       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_slot = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < cnt_q && idx_q[lk_slot] == lookup_index_i) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = row_q[lk_slot];
            end
        end
    end

    assign head_index_o = idx_q[rd_ptr_q];
    assign head_wdata_o = row_q[rd_ptr_q];
    assign count_o      = cnt_q;

endmodule

// File: rtl/perceptron_table_scheduler.sv
// Single-port weight-table arbiter: prediction reads win, training
// writes are queued, forced after a defer bound, and forwarded to reads.
module perceptron_table_scheduler
    import global_parameters::*;
#(
    parameter int IDX_W       = PERCEPTRON_INDEX_WIDTH,
    parameter int ROW_W       = PERCEPTRON_ROW_WIDTH,
    parameter int QUEUE_DEPTH = SCHED_QUEUE_DEPTH,
    parameter int MAX_DEFER   = SCHED_MAX_DEFER,
    parameter int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_index,
    output logic             pred_grant,
    output logic             pred_stall,
    input  logic             train_valid,
    output logic             train_ready,
    input  logic [IDX_W-1:0] train_index,
    input  logic [ROW_W-1:0] train_wdata,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_index,
    output logic [ROW_W-1:0] tbl_wdata,
    output logic             fwd_hit,
    output logic [ROW_W-1:0] fwd_data,
    output logic [CNT_W-1:0] queue_count
);

    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    logic [CNT_W-1:0] q_count;
    logic [IDX_W-1:0] head_idx;
    logic [ROW_W-1:0] head_row;
    logic             lk_hit;
    logic [ROW_W-1:0] lk_row;
    logic             q_empty, q_full, force_wr;
    logic             grant, wr_issue, push;
    logic [DEF_W-1:0] defer_q, defer_d;
    logic             fwd_hit_q, fwd_hit_d;
    logic [ROW_W-1:0] fwd_data_q, fwd_data_d;

    assign train_ready = q_count < CNT_W'(QUEUE_DEPTH);
    assign push        = train_valid && train_ready;

    train_write_queue #(
        .DEPTH (QUEUE_DEPTH),
        .IDX_W (IDX_W),
        .ROW_W (ROW_W),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk            (clk),
        .rst            (rst),
        .push_i         (push),
        .push_index_i   (train_index),
        .push_wdata_i   (train_wdata),
        .pop_i          (wr_issue),
        .head_index_o   (head_idx),
        .head_wdata_o   (head_row),
        .count_o        (q_count),
        .lookup_index_i (pred_index),
        .lookup_hit_o   (lk_hit),
        .lookup_data_o  (lk_row)
    );

    always_comb begin
        q_empty  = q_count == '0;
        q_full   = q_count == CNT_W'(QUEUE_DEPTH);
        force_wr = !q_empty && (q_full || defer_q == DEF_W'(MAX_DEFER));
        grant    = !rst && pred_valid && !force_wr;
        wr_issue = !rst && !q_empty && !grant;
    end

    always_comb begin
        pred_grant = grant;
        pred_stall = !rst && pred_valid && !grant;
        tbl_en     = grant || wr_issue;
        tbl_we     = wr_issue;
        tbl_index  = '0;
        tbl_wdata  = '0;
        if (wr_issue) begin
            tbl_index = head_idx;
            tbl_wdata = head_row;
        end else if (grant) begin
            tbl_index = pred_index;
        end
    end

    always_comb begin
        defer_d = defer_q;
        if (wr_issue || q_empty) begin
            defer_d = '0;
        end else if (defer_q != DEF_W'(MAX_DEFER)) begin
            defer_d = defer_q + 1'b1;
        end
        fwd_hit_d  = grant && lk_hit;
        fwd_data_d = fwd_hit_d ? lk_row : fwd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            defer_q    <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            defer_q    <= defer_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign fwd_hit     = fwd_hit_q;
    assign fwd_data    = fwd_data_q;
    assign queue_count = q_count;

endmodule

// File: doc/perceptron_table_scheduler.md
Name: perceptron_table_scheduler

Overview:
- Shares the single-ported perceptron weight-table SRAM between two requesters: prediction reads (front end) and training write-backs (retire/update logic).
- Buffers training writes in a small in-order queue and arbitrates one table access per cycle.
- Gives predictions priority, with a starvation bound for writes.
- Forwards queued-but-unwritten rows to predictions, so a read never returns data older than an accepted update.

Parameters:
- IDX_W, 11, table index width (log2 of PERCEPTRON_TABLE_NUM_ENTRIES = 2048).
- ROW_W, 320, weight row width (PERCEPTRON_NUM_WEIGHTS * PERCEPTRON_WEIGHT_WIDTH).
- QUEUE_DEPTH, 4, training write queue entries (power of two, ≥ 2).
- MAX_DEFER, 8, consecutive deferred-write cycles before a write is forced.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pred_valid  in  1  prediction read request
- pred_index  in  IDX_W  row to read
- pred_grant  out  1  read issued to table this cycle
- pred_stall  out  1  pred_valid && !pred_grant
- train_valid  in  1  training write offered
- train_ready  out  1  queue can accept (registered fullness)
- train_index  in  IDX_W  row to write
- train_wdata  in  ROW_W  new weight row
- tbl_en  out  1  SRAM access enable
- tbl_we  out  1  1 = write, 0 = read
- tbl_index  out  IDX_W  SRAM address
- tbl_wdata  out  ROW_W  SRAM write data
- fwd_hit  out  1  one cycle after a grant: queued row supersedes SRAM read data
- fwd_data  out  ROW_W  forwarded row, valid when fwd_hit
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupancy

Behaviour:
Reset:
- While rst is high: queue emptied (pending writes dropped), defer counter = 0.
- All outputs 0, except train_ready = 1 once the queue is empty.
- rst asserted mid-operation aborts everything. There are no partial writes because writes are single-cycle.

Queue:
- Enqueue when train_valid && train_ready.
- train_ready = (count < QUEUE_DEPTH), computed from the registered count. When full, no enqueue even if a dequeue occurs in the same cycle.
- An entry enqueued in cycle N is eligible for issue from cycle N+1; there is no same-cycle bypass to the SRAM.
- Dequeue order is strict FIFO. Pointers wrap modulo QUEUE_DEPTH.

Arbitration (combinational, per cycle):
- force_wr = queue non-empty && (count == QUEUE_DEPTH || defer_cnt == MAX_DEFER).
- If force_wr: issue head write; pred_grant = 0.
- Else if pred_valid: issue read; pred_grant = 1.
- Else if queue non-empty: issue head write.
- Else: tbl_en = 0.
- Write issue: tbl_en = 1, tbl_we = 1, tbl_index/tbl_wdata = head entry; dequeue at the clock edge.
- Read issue: tbl_en = 1, tbl_we = 0, tbl_index = pred_index.

defer_cnt:
- Reset to 0 on a write issue or when the queue is empty.
- Otherwise increments each cycle a non-empty queue loses to a read; saturates at MAX_DEFER.

Forwarding:
- On a read grant in cycle N, compare pred_index against all valid queue entries as of cycle N. Same-cycle incoming train_* is not compared.
- The youngest match wins.
- Register the result: fwd_hit/fwd_data are valid in cycle N+1, aligned with SRAM read data.
- fwd_hit = 0 in any cycle not following a grant. fwd_data holds its value when fwd_hit = 0; consumers must ignore it.
- The head entry being written in N cannot coincide with a read in N.

Widths:
- No arithmetic besides the pointer, count and defer counters.
- Count is one bit wider than the pointers to distinguish full from empty.

Decomposition:
- Package global_parameters gains:
  - PERCEPTRON_INDEX_WIDTH = $clog2(PERCEPTRON_TABLE_NUM_ENTRIES)
  - PERCEPTRON_ROW_WIDTH = PERCEPTRON_NUM_WEIGHTS * PERCEPTRON_WEIGHT_WIDTH
  - SCHED_QUEUE_DEPTH = 4
  - SCHED_MAX_DEFER = 8
  - packed struct train_entry_t {index, wdata}
- One natural sub-module: train_write_queue. It implements the FIFO storage plus an associative youngest-match lookup port. The top level keeps the arbiter, defer counter and forwarding register.
- One instance serves each of the NUM_TABLES = 4 skewed tables.

Test Plan:
1. Reset mid-traffic: rst asserted with 3 queued writes -> queue_count = 0, tbl_en = 0, fwd_hit = 0, and no write issues after rst deasserts.
2. Idle write drain: enqueue idx 5 then idx 9, with pred_valid = 0 -> tbl write idx 5 in cycle +1, idx 9 in cycle +2, count returns to 0.
3. Priority and starvation: 1 queued write plus pred_valid held high -> 8 read grants, then a forced write in the 9th cycle (pred_stall = 1 that cycle), then defer_cnt returns to 0.
4. Full queue: 4 enqueues with reads continuously pending -> train_ready = 0, the next cycle is a forced write, and train_ready returns to 1 one cycle later.
5. Forwarding: queue idx 7 row A then idx 7 row B, then read idx 7 -> next cycle fwd_hit = 1 and fwd_data = B. A read of idx 8 gives fwd_hit = 0.
6. Same-cycle enqueue/read of idx 3 with an empty queue -> fwd_hit = 0 (no same-cycle compare), and the write issues the following cycle.
